// File: rtl/pe_fifo_pkg.sv
// Shared helpers for the PE token FIFOs: clog2, DEPTH legality and occupancy width.
package pe_fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit depth_legal(input int depth, input int addr_width);
    return (depth >= 2) && (depth <= (1 << addr_width)) && (addr_width == clog2(depth));
  endfunction

  function automatic int occ_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/pe_start_token_srl.sv
// Bare write-enabled shift register; the newest token enters slot 0. Contents are never reset.
module pe_start_token_srl
  import pe_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] slot [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      slot[0] <= din;
      for (int i = 1; i < DEPTH; i++) slot[i] <= slot[i-1];
    end
  end

  // Addresses beyond DEPTH-1 only occur for non-power-of-two depths while empty.
  assign dout = (int'(addr) < DEPTH) ? slot[addr] : '0;

endmodule

// File: rtl/pe_start_token_fifo.sv
// Start-token FIFO between producer and consumer PEs; owns flow control and registered flags.
// Optional occupancy tap: define PE_START_FIFO_OCCUPANCY_EN to add if_num_data_valid.
module pe_start_token_fifo
  import pe_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout
`ifdef PE_START_FIFO_OCCUPANCY_EN
  ,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
`endif
);

  localparam int OCC_W = occ_width(ADDR_WIDTH);
  localparam bit DEPTH_OK = depth_legal(DEPTH, ADDR_WIDTH);
  localparam logic [OCC_W-1:0] CNT_ONE = OCC_W'(1);
  localparam logic [OCC_W-1:0] CNT_FULL = OCC_W'(DEPTH);

  if (!DEPTH_OK) begin : g_bad_depth
    $error("pe_start_token_fifo: DEPTH/ADDR_WIDTH combination is illegal");
  end

  logic [OCC_W-1:0]      cnt;
  logic [OCC_W-1:0]      cnt_next;
  logic [OCC_W-1:0]      cnt_m1;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_acc;
  logic                  rd_acc;

  assign wr_acc  = if_write & if_write_ce & if_full_n;
  assign rd_acc  = if_read & if_read_ce & if_empty_n;
  assign cnt_m1  = cnt - CNT_ONE;
  assign rd_addr = cnt_m1[ADDR_WIDTH-1:0];

  always_comb begin
    cnt_next = cnt;
    if (wr_acc && !rd_acc)      cnt_next = cnt + CNT_ONE;
    else if (rd_acc && !wr_acc) cnt_next = cnt - CNT_ONE;
  end

  // Flags are registered from cnt_next so no input reaches them combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      if_empty_n <= 1'b0;
      if_full_n  <= 1'b1;
    end else begin
      cnt        <= cnt_next;
      if_empty_n <= (cnt_next != '0);
      if_full_n  <= (cnt_next != CNT_FULL);
    end
  end

`ifdef PE_START_FIFO_OCCUPANCY_EN
  assign if_num_data_valid = cnt;
`endif

  pe_start_token_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk  (clk),
    .we   (wr_acc),
    .addr (rd_addr),
    .din  (if_din),
    .dout (if_dout)
  );

endmodule

// File: tb/tb_pe_start_token_fifo.sv
// Directed self-checking bench for pe_start_token_fifo with DEPTH=4, DATA_WIDTH=8.
module tb_pe_start_token_fifo;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_full_n;
  logic          if_write_ce;
  logic          if_write;
  logic [DW-1:0] if_din;
  logic          if_empty_n;
  logic          if_read_ce;
  logic          if_read;
  logic [DW-1:0] if_dout;
`ifdef PE_START_FIFO_OCCUPANCY_EN
  logic [AW:0]   if_num_data_valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_start_token_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk         (clk),
    .reset       (reset),
    .if_full_n   (if_full_n),
    .if_write_ce (if_write_ce),
    .if_write    (if_write),
    .if_din      (if_din),
    .if_empty_n  (if_empty_n),
    .if_read_ce  (if_read_ce),
    .if_read     (if_read),
    .if_dout     (if_dout)
`ifdef PE_START_FIFO_OCCUPANCY_EN
    ,
    .if_num_data_valid (if_num_data_valid)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [DW-1:0] d);
    if_write    = wr;
    if_read     = rd;
    if_write_ce = 1'b1;
    if_read_ce  = 1'b1;
    if_din      = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    cyc();
    n_checks++;
    if (if_empty_n !== 1'b0) begin n_fail++; $display("FAIL reset_empty_n: got %b want 0", if_empty_n); end
    n_checks++;
    if (if_full_n !== 1'b1) begin n_fail++; $display("FAIL reset_full_n: got %b want 1", if_full_n); end
    reset = 1'b0;
    drive(1'b0, 1'b1, 8'h00);
    cyc();
    cyc();
    n_checks++;
    if (if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
      n_fail++; $display("FAIL idle_read_refused: empty_n=%b full_n=%b want 0/1", if_empty_n, if_full_n);
    end
`ifdef PE_START_FIFO_OCCUPANCY_EN
    n_checks++;
    if (if_num_data_valid !== 3'd0) begin n_fail++; $display("FAIL idle_occ: got %0d want 0", if_num_data_valid); end
`endif
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] exp_tok [4];
    exp_tok[0] = 8'h11; exp_tok[1] = 8'h22; exp_tok[2] = 8'h33; exp_tok[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, exp_tok[i]);
      cyc();
      n_checks++;
      if (if_empty_n !== 1'b1 || if_full_n !== (i < 3)) begin
        n_fail++; $display("FAIL fill_flags[%0d]: empty_n=%b full_n=%b want 1/%0d", i, if_empty_n, if_full_n, (i < 3));
      end
    end
    drive(1'b1, 1'b0, 8'h55);
    cyc();
    n_checks++;
    if (if_full_n !== 1'b0 || if_dout !== 8'h11) begin
      n_fail++; $display("FAIL write_when_full: full_n=%b dout=%h want 0/11", if_full_n, if_dout);
    end
`ifdef PE_START_FIFO_OCCUPANCY_EN
    n_checks++;
    if (if_num_data_valid !== 3'd4) begin n_fail++; $display("FAIL full_occ: got %0d want 4", if_num_data_valid); end
`endif
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      n_checks++;
      if (if_dout !== exp_tok[i]) begin n_fail++; $display("FAIL drain_dout[%0d]: got %h want %h", i, if_dout, exp_tok[i]); end
      cyc();
      n_checks++;
      if (if_full_n !== 1'b1 || if_empty_n !== (i < 3)) begin
        n_fail++; $display("FAIL drain_flags[%0d]: full_n=%b empty_n=%b want 1/%0d", i, if_full_n, if_empty_n, (i < 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 8'hA0); cyc();
    drive(1'b1, 1'b0, 8'hA1); cyc();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 8'(8'hA2 + k));
      n_checks++;
      if (if_dout !== 8'(8'hA0 + k)) begin n_fail++; $display("FAIL stream_dout[%0d]: got %h want %h", k, if_dout, 8'(8'hA0 + k)); end
      cyc();
      n_checks++;
      if (if_empty_n !== 1'b1 || if_full_n !== 1'b1) begin
        n_fail++; $display("FAIL stream_flags[%0d]: empty_n=%b full_n=%b want 1/1", k, if_empty_n, if_full_n);
      end
`ifdef PE_START_FIFO_OCCUPANCY_EN
      n_checks++;
      if (if_num_data_valid !== 3'd2) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d want 2", k, if_num_data_valid); end
`endif
    end
    drive(1'b0, 1'b1, 8'h00);
    n_checks++;
    if (if_dout !== 8'hA8) begin n_fail++; $display("FAIL stream_tail0: got %h want a8", if_dout); end
    cyc();
    n_checks++;
    if (if_dout !== 8'hA9) begin n_fail++; $display("FAIL stream_tail1: got %h want a9", if_dout); end
    cyc();
    n_checks++;
    if (if_empty_n !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got %b want 0", if_empty_n); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'(8'hB0 + i));
      cyc();
    end
    drive(1'b1, 1'b1, 8'h66);
    n_checks++;
    if (if_dout !== 8'hB0 || if_full_n !== 1'b0) begin
      n_fail++; $display("FAIL full_rw_pre: dout=%h full_n=%b want b0/0", if_dout, if_full_n);
    end
    cyc();
    n_checks++;
    if (if_full_n !== 1'b1 || if_empty_n !== 1'b1 || if_dout !== 8'hB1) begin
      n_fail++; $display("FAIL full_rw_post: full_n=%b empty_n=%b dout=%h want 1/1/b1", if_full_n, if_empty_n, if_dout);
    end
`ifdef PE_START_FIFO_OCCUPANCY_EN
    n_checks++;
    if (if_num_data_valid !== 3'd3) begin n_fail++; $display("FAIL full_rw_occ: got %0d want 3", if_num_data_valid); end
`endif
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      n_checks++;
      if (if_dout !== 8'(8'hB1 + i)) begin n_fail++; $display("FAIL full_rw_drain[%0d]: got %h want %h", i, if_dout, 8'(8'hB1 + i)); end
      cyc();
    end
    n_checks++;
    if (if_empty_n !== 1'b0) begin n_fail++; $display("FAIL full_rw_empty: got %b want 0", if_empty_n); end
  endtask

  task automatic test_empty_rw();
    drive(1'b1, 1'b1, 8'h7E);
    cyc();
    n_checks++;
    if (if_empty_n !== 1'b1 || if_dout !== 8'h7E || if_full_n !== 1'b1) begin
      n_fail++; $display("FAIL empty_rw: empty_n=%b dout=%h full_n=%b want 1/7e/1", if_empty_n, if_dout, if_full_n);
    end
    drive(1'b0, 1'b1, 8'h00);
    cyc();
    n_checks++;
    if (if_empty_n !== 1'b0) begin n_fail++; $display("FAIL empty_rw_single: empty_n=%b want 0", if_empty_n); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'(8'hC0 + i));
      cyc();
    end
    drive(1'b1, 1'b1, 8'hEE);
    if_write_ce = 1'b0;
    if_read_ce  = 1'b0;
    cyc();
    cyc();
    n_checks++;
    if (if_empty_n !== 1'b1 || if_full_n !== 1'b1 || if_dout !== 8'hC0) begin
      n_fail++; $display("FAIL gated_no_change: empty_n=%b full_n=%b dout=%h want 1/1/c0", if_empty_n, if_full_n, if_dout);
    end
`ifdef PE_START_FIFO_OCCUPANCY_EN
    n_checks++;
    if (if_num_data_valid !== 3'd3) begin n_fail++; $display("FAIL gated_occ: got %0d want 3", if_num_data_valid); end
`endif
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: empty_n=%b full_n=%b want 0/1", if_empty_n, if_full_n);
    end
    drive(1'b0, 1'b0, 8'h00);
    cyc();
    reset = 1'b0;
    cyc();
    n_checks++;
    if (if_empty_n !== 1'b0) begin n_fail++; $display("FAIL post_reset_empty: got %b want 0", if_empty_n); end
    drive(1'b1, 1'b0, 8'hD5);
    cyc();
    n_checks++;
    if (if_dout !== 8'hD5 || if_empty_n !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_write: dout=%h empty_n=%b want d5/1", if_dout, if_empty_n);
    end
    drive(1'b0, 1'b1, 8'h00);
    cyc();
    n_checks++;
    if (if_empty_n !== 1'b0) begin n_fail++; $display("FAIL post_reset_discard: empty_n=%b want 0", if_empty_n); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_rw();
    test_empty_rw();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
